// File: rtl/player_grid_ctrl.sv
// Grid-stepping player controller: button edges to clamped STEP moves, level exits and event pulses.
// Optional hold-to-repeat movement is built when PLAYER_AUTOREPEAT_EN is defined.
module player_grid_ctrl #(
    parameter int COORD_W       = 10,
    parameter int LEVEL_W       = 10,
    parameter int STEP          = 40,
    parameter int H_MIN_POS     = 0,
    parameter int H_MAX_POS     = 600,
    parameter int V_MIN_POS     = 40,
    parameter int V_MAX_POS     = 440,
    parameter int START_H       = 40,
    parameter int START_V       = 240,
    parameter int MAX_LEVEL     = 9,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic               i_clk,
    input  logic               i_reset_player,
    input  logic               i_clear_level,
    input  logic               i_pause,
    input  logic               i_up,
    input  logic               i_down,
    input  logic               i_left,
    input  logic               i_right,
    output logic [COORD_W-1:0] o_new_h,
    output logic [COORD_W-1:0] o_new_v,
    output logic [LEVEL_W-1:0] o_next_level,
    output logic               o_moved,
    output logic               o_blocked,
    output logic               o_level_up,
    output logic               o_game_won,
    output logic [1:0]         o_state
);

`ifdef PLAYER_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] L_DLY_M1 = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] L_PER_M1 = TMR_W'(REPEAT_PERIOD - 1);

    logic [TMR_W-1:0] r_timer;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1
    } state_t;
`endif

    // Direction codes index the button vector {up, down, left, right}.
    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    localparam logic [COORD_W:0]   L_STEP  = (COORD_W+1)'(STEP);
    localparam logic [COORD_W:0]   L_H_MIN = (COORD_W+1)'(H_MIN_POS);
    localparam logic [COORD_W:0]   L_H_MAX = (COORD_W+1)'(H_MAX_POS);
    localparam logic [COORD_W:0]   L_V_MIN = (COORD_W+1)'(V_MIN_POS);
    localparam logic [COORD_W:0]   L_V_MAX = (COORD_W+1)'(V_MAX_POS);
    localparam logic [LEVEL_W-1:0] L_LVL_MAX = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] L_LVL_ONE = LEVEL_W'(1);

    state_t             r_state;
    logic [COORD_W-1:0] r_h;
    logic [COORD_W-1:0] r_v;
    // Level survives reset_player; only power-up and clear_level return it to 1.
    logic [LEVEL_W-1:0] r_level = LEVEL_W'(1);
    logic [3:0]         r_prev_btn;
    logic [1:0]         r_dir;
    logic               r_moved;
    logic               r_blocked;
    logic               r_level_up;
    logic               r_game_won;

    logic [3:0]         w_btn;
    logic [3:0]         w_press;
    logic               w_press_any;
    logic [1:0]         w_press_dir;
    logic [1:0]         w_mv_dir;
    logic               w_dir_held;
    logic               w_fire;
    logic [COORD_W:0]   w_h_ext;
    logic [COORD_W:0]   w_v_ext;
    logic [COORD_W-1:0] w_nxt_h;
    logic [COORD_W-1:0] w_nxt_v;
    logic [LEVEL_W-1:0] w_nxt_lvl;
    logic               w_ok;
    logic               w_lu;
    logic               w_gw;

    assign w_btn       = {i_up, i_down, i_left, i_right};
    assign w_press     = w_btn & ~r_prev_btn;
    assign w_press_any = |w_press;
    assign w_dir_held  = w_btn[r_dir];
    assign w_mv_dir    = w_press_any ? w_press_dir : r_dir;
    assign w_h_ext     = {1'b0, r_h};
    assign w_v_ext     = {1'b0, r_v};

    always_comb begin
        w_press_dir = DIR_RIGHT;
        if (w_press[3])      w_press_dir = DIR_UP;
        else if (w_press[2]) w_press_dir = DIR_DOWN;
        else if (w_press[1]) w_press_dir = DIR_LEFT;
    end

    // A fresh press always fires; a repeat fires only while the resolved direction is still held.
    always_comb begin
        w_fire = w_press_any;
`ifdef PLAYER_AUTOREPEAT_EN
        if (!w_press_any && w_dir_held) begin
            if (r_state == ST_HELD && r_timer == L_DLY_M1)
                w_fire = 1'b1;
            if (r_state == ST_REPEAT && r_timer == L_PER_M1)
                w_fire = 1'b1;
        end
`endif
    end

    // Bounds are compared one bit wider than the coordinates so additions cannot wrap.
    always_comb begin
        w_nxt_h   = r_h;
        w_nxt_v   = r_v;
        w_nxt_lvl = r_level;
        w_ok      = 1'b1;
        w_lu      = 1'b0;
        w_gw      = 1'b0;
        case (w_mv_dir)
            DIR_UP: begin
                if (w_v_ext >= L_V_MIN + L_STEP) w_nxt_v = r_v - COORD_W'(STEP);
                else                             w_ok    = 1'b0;
            end
            DIR_DOWN: begin
                if (w_v_ext + L_STEP <= L_V_MAX) w_nxt_v = r_v + COORD_W'(STEP);
                else                             w_ok    = 1'b0;
            end
            DIR_LEFT: begin
                if (w_h_ext >= L_H_MIN + L_STEP) w_nxt_h = r_h - COORD_W'(STEP);
                else                             w_ok    = 1'b0;
            end
            default: begin
                if (w_h_ext + L_STEP <= L_H_MAX) begin
                    w_nxt_h = r_h + COORD_W'(STEP);
                end else begin
                    w_nxt_h = COORD_W'(H_MIN_POS);
                    if (r_level < L_LVL_MAX) begin
                        w_nxt_lvl = r_level + L_LVL_ONE;
                        w_lu      = 1'b1;
                    end else begin
                        w_gw = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset_player) begin
            r_h        <= COORD_W'(START_H);
            r_v        <= COORD_W'(START_V);
            r_state    <= ST_IDLE;
            r_dir      <= DIR_RIGHT;
            r_prev_btn <= 4'b0000;
            r_moved    <= 1'b0;
            r_blocked  <= 1'b0;
            r_level_up <= 1'b0;
            r_game_won <= 1'b0;
`ifdef PLAYER_AUTOREPEAT_EN
            r_timer    <= '0;
`endif
            if (i_clear_level)
                r_level <= L_LVL_ONE;
        end else begin
            r_prev_btn <= w_btn;
            r_moved    <= 1'b0;
            r_blocked  <= 1'b0;
            r_level_up <= 1'b0;
            r_game_won <= 1'b0;
            if (!i_pause) begin
                if (w_fire) begin
                    r_h        <= w_nxt_h;
                    r_v        <= w_nxt_v;
                    r_level    <= w_nxt_lvl;
                    r_moved    <= w_ok;
                    r_blocked  <= ~w_ok;
                    r_level_up <= w_lu;
                    r_game_won <= w_gw;
                end
                if (w_press_any) begin
                    r_state <= ST_HELD;
                    r_dir   <= w_press_dir;
`ifdef PLAYER_AUTOREPEAT_EN
                    r_timer <= '0;
`endif
                end else if (r_state != ST_IDLE && !w_dir_held) begin
                    r_state <= ST_IDLE;
`ifdef PLAYER_AUTOREPEAT_EN
                    r_timer <= '0;
`endif
                end
`ifdef PLAYER_AUTOREPEAT_EN
                else if (r_state == ST_HELD) begin
                    if (r_timer == L_DLY_M1) begin
                        r_state <= ST_REPEAT;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end else if (r_state == ST_REPEAT) begin
                    if (r_timer == L_PER_M1) r_timer <= '0;
                    else                     r_timer <= r_timer + 1'b1;
                end
`endif
            end
            // Clearing wins over a same-cycle level exit.
            if (i_clear_level)
                r_level <= L_LVL_ONE;
        end
    end

    assign o_new_h      = r_h;
    assign o_new_v      = r_v;
    assign o_next_level = r_level;
    assign o_moved      = r_moved;
    assign o_blocked    = r_blocked;
    assign o_level_up   = r_level_up;
    assign o_game_won   = r_game_won;
    assign o_state      = r_state;

endmodule

// File: tb/tb_player_grid_ctrl.sv
// Scoreboard bench for player_grid_ctrl: stimulus pushes expected events, a negedge monitor pops them.
// Directed vectors; the hold-to-repeat sequence is checked when PLAYER_AUTOREPEAT_EN is defined.
module tb_player_grid_ctrl;

    logic       clk = 1'b0;
    logic       reset_player, clear_level, pause;
    logic       up, down, left, right;
    logic [9:0] new_h, new_v, next_level;
    logic       moved, blocked, level_up, game_won;
    logic [1:0] state;

    int n_cmp = 0;
    int n_err = 0;
    logic [33:0] exp_q[$];
    int m_h, m_v, m_lvl;

    always #5 clk = ~clk;

    player_grid_ctrl #(
        .REPEAT_DELAY (4),
        .REPEAT_PERIOD(2)
    ) dut (
        .i_clk         (clk),
        .i_reset_player(reset_player),
        .i_clear_level (clear_level),
        .i_pause       (pause),
        .i_up          (up),
        .i_down        (down),
        .i_left        (left),
        .i_right       (right),
        .o_new_h       (new_h),
        .o_new_v       (new_v),
        .o_next_level  (next_level),
        .o_moved       (moved),
        .o_blocked     (blocked),
        .o_level_up    (level_up),
        .o_game_won    (game_won),
        .o_state       (state)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic [3:0] b);
        {up, down, left, right} = b;
    endtask

    // Reference behaviour for one move in direction 3=up 2=down 1=left 0=right.
    task automatic push_step(input int dir);
        logic mv, bl, lu, gw;
        mv = 1'b0; bl = 1'b0; lu = 1'b0; gw = 1'b0;
        case (dir)
            3: if (m_v >= 80)        begin m_v -= 40; mv = 1'b1; end else bl = 1'b1;
            2: if (m_v + 40 <= 440)  begin m_v += 40; mv = 1'b1; end else bl = 1'b1;
            1: if (m_h >= 40)        begin m_h -= 40; mv = 1'b1; end else bl = 1'b1;
            default: begin
                mv = 1'b1;
                if (m_h + 40 <= 600) m_h += 40;
                else begin
                    m_h = 0;
                    if (m_lvl < 9) begin m_lvl++; lu = 1'b1; end
                    else gw = 1'b1;
                end
            end
        endcase
        exp_q.push_back({10'(m_h), 10'(m_v), 10'(m_lvl), mv, bl, lu, gw});
    endtask

    task automatic press(input logic [3:0] b);
        if (b[3])      push_step(3);
        else if (b[2]) push_step(2);
        else if (b[1]) push_step(1);
        else if (b[0]) push_step(0);
        set_btn(b);
        tick;
        set_btn(4'b0000);
        tick;
    endtask

    task automatic do_reset(input logic clr);
        reset_player = 1'b1;
        clear_level  = clr;
        tick;
        reset_player = 1'b0;
        clear_level  = 1'b0;
        m_h = 40;
        m_v = 240;
        if (clr) m_lvl = 1;
    endtask

    // Monitor: every cycle carrying an event pulse must match the next expected event.
    always @(negedge clk) begin
        if (moved || blocked || level_up || game_won) begin
            logic [33:0] got, exp;
            got = {new_h, new_v, next_level, moved, blocked, level_up, game_won};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL event_unexpected: got h=%0d v=%0d lvl=%0d pulses=%b, required no event",
                         new_h, new_v, next_level, got[3:0]);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL event: got h=%0d v=%0d lvl=%0d pulses=%b, required h=%0d v=%0d lvl=%0d pulses=%b",
                             got[33:24], got[23:14], got[13:4], got[3:0],
                             exp[33:24], exp[23:14], exp[13:4], exp[3:0]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_player = 1'b1;
        clear_level  = 1'b0;
        pause        = 1'b0;
        set_btn(4'b0000);
        tick;
        tick;
        reset_player = 1'b0;
        m_h = 40; m_v = 240; m_lvl = 1;

        chk("reset_h", int'(new_h), 40);
        chk("reset_v", int'(new_v), 240);
        chk("reset_level", int'(next_level), 1);
        chk("reset_pulses", int'({moved, blocked, level_up, game_won}), 0);
        chk("reset_state", int'(state), 0);

        // Up moves to the top row, then one blocked press.
        press(4'b1000);
        chk("up_once_v", int'(new_v), 200);
        repeat (4) press(4'b1000);
        chk("up_top_v", int'(new_v), 40);
        press(4'b1000);
        chk("up_blocked_v", int'(new_v), 40);

        // Simultaneous up+right resolves to up only.
        do_reset(1'b0);
        press(4'b1001);
        chk("prio_v", int'(new_v), 200);
        chk("prio_h", int'(new_h), 40);

        // Down pressed and held through pause: no move during or after.
        pause = 1'b1;
        set_btn(4'b0100);
        repeat (3) tick;
        pause = 1'b0;
        repeat (3) tick;
        set_btn(4'b0000);
        tick;
        chk("pause_v", int'(new_v), 200);
        chk("pause_h", int'(new_h), 40);

        // Walk right through level exits up to h=600 on level 3.
        do_reset(1'b0);
        while (!(m_lvl == 3 && m_h == 600)) press(4'b0001);
        chk("pre_exit_h", int'(new_h), 600);
        chk("pre_exit_level", int'(next_level), 3);
        press(4'b0001);
        chk("exit_h", int'(new_h), 0);
        chk("exit_level", int'(next_level), 4);
        while (!(m_lvl == 9 && m_h == 600)) press(4'b0001);
        press(4'b0001);
        chk("won_level", int'(next_level), 9);
        chk("won_h", int'(new_h), 0);

        // reset_player keeps the level; clear_level alone restores 1.
        do_reset(1'b0);
        chk("rst_keep_h", int'(new_h), 40);
        chk("rst_keep_v", int'(new_v), 240);
        chk("rst_keep_level", int'(next_level), 9);
        clear_level = 1'b1;
        tick;
        clear_level = 1'b0;
        m_lvl = 1;
        chk("clear_level", int'(next_level), 1);
        chk("clear_h", int'(new_h), 40);

        // Left and bottom boundaries.
        press(4'b0010);
        press(4'b0010);
        chk("left_edge_h", int'(new_h), 0);
        repeat (5) press(4'b0100);
        press(4'b0100);
        chk("bottom_edge_v", int'(new_v), 440);

        // reset_player together with clear_level.
        while (m_lvl != 2) press(4'b0001);
        do_reset(1'b1);
        chk("rst_clr_h", int'(new_h), 40);
        chk("rst_clr_v", int'(new_v), 240);
        chk("rst_clr_level", int'(next_level), 1);

        // Hold left from h=400.
        while (m_h != 400) press(4'b0001);
        push_step(1);
`ifdef PLAYER_AUTOREPEAT_EN
        repeat (11) push_step(1);
`endif
        set_btn(4'b0010);
        tick;
        chk("hold_press_h", int'(new_h), 360);
        repeat (3) tick;
        chk("hold_pre_repeat_h", int'(new_h), 360);
        tick;
`ifdef PLAYER_AUTOREPEAT_EN
        chk("hold_first_repeat_h", int'(new_h), 320);
`else
        chk("hold_no_repeat_h", int'(new_h), 360);
`endif
        repeat (21) tick;
        set_btn(4'b0000);
        tick;
        tick;
`ifdef PLAYER_AUTOREPEAT_EN
        chk("hold_final_h", int'(new_h), 0);
`else
        chk("hold_final_h", int'(new_h), 360);
`endif
        chk("hold_idle_state", int'(state), 0);

        repeat (3) tick;
        chk("scoreboard_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
